// File: rtl/mult_hilo_sequencer.sv
// Multi-cycle 32x32 MULT/MULTU sequencer with architectural HI/LO registers.
// A single 16x16 combinational multiplier is time-shared over four partial-product
// states; a final FIX state applies the sign and commits the result to HI/LO.

module multiplier_16x16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);

    // Unsigned 16x16 -> 32-bit product
    always_comb begin
        p = 32'(x) * 32'(y);
    end

endmodule

module mult_hilo_sequencer #(
    parameter bit SIGNED_EN = 1'b1,
    parameter bit FAST_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3, StFix} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        neg_q, neg_d;
    logic        zero_q, zero_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] a_abs, b_abs;
    logic [15:0] mul_x, mul_y;
    logic [31:0] prod;
    logic [63:0] result;

    // Operand half selection: P2/P3 use the high half of a, P1/P3 the high half of b
    always_comb begin
        mul_x = ((state_q == StP2) || (state_q == StP3)) ? a_mag_q[31:16] : a_mag_q[15:0];
        mul_y = ((state_q == StP1) || (state_q == StP3)) ? b_mag_q[31:16] : b_mag_q[15:0];
    end

    multiplier_16x16 u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // Operand magnitudes and sign-corrected final result
    always_comb begin
        signed_op = SIGNED_EN && is_signed;
        // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude
        a_abs     = (signed_op && a[31]) ? (~a + 32'd1) : a;
        b_abs     = (signed_op && b[31]) ? (~b + 32'd1) : b;
        result    = neg_q ? (~acc_q + 64'd1) : acc_q;
    end

    // Next-state logic for the sequencer and HI/LO
    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // MTHI/MTLO only land while idle; a same-cycle start overwrites later
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    neg_d   = signed_op && (a[31] ^ b[31]);
                    zero_d  = (a == 32'd0) || (b == 32'd0);
                    acc_d   = 64'd0;
                    busy_d  = 1'b1;
                    state_d = StP0;
                end
            end
            StP0: begin
                acc_d   = acc_q + {32'd0, prod};
                // A zero operand makes every partial product zero; skip straight to FIX
                state_d = (FAST_ZERO && zero_q) ? StFix : StP1;
            end
            StP1: begin
                acc_d   = acc_q + {16'd0, prod, 16'd0};
                state_d = StP2;
            end
            StP2: begin
                acc_d   = acc_q + {16'd0, prod, 16'd0};
                state_d = StP3;
            end
            StP3: begin
                acc_d   = acc_q + {prod, 32'd0};
                state_d = StFix;
            end
            StFix: begin
                hi_d    = result[63:32];
                lo_d    = result[31:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any multiply in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Self-checking bench for mult_hilo_sequencer: directed vectors, handshake corner cases,
// reset abort, HI/LO writes and a random signed/unsigned sweep against a 64-bit model.

module tb_mult_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_hilo;

    mult_hilo_sequencer #(
        .SIGNED_EN (1'b1),
        .FAST_ZERO (1'b0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // 64-bit reference product (low 64 bits of the sign/zero-extended product)
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input bit s);
        logic [63:0] xe, ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // mode 0: plain; 1: start spammed while busy; 2: MTHI/MTLO with start; 3: writes while busy
    task automatic mul_op(input logic [31:0] ta, input logic [31:0] tb, input bit ts,
                          input int mode);
        int          cyc;
        logic [63:0] expv;
        @(negedge clk);
        start     = 1'b1;
        a         = ta;
        b         = tb;
        is_signed = ts;
        if (mode == 2) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hA5A5_5A5A;
        end
        sb_q.push_back(ref_mul(ta, tb, ts));
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (mode == 2) exp_hilo = {32'hA5A5_5A5A, 32'hA5A5_5A5A};
        check_eq("busy_after_start", 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            check_eq("hilo_stable", {hi, lo}, exp_hilo);
            if (mode == 1 && cyc < 4) begin
                start     = 1'b1;
                a         = $urandom;
                b         = $urandom;
                is_signed = 1'($urandom);
            end
            if (mode == 3 && cyc < 3) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            cyc++;
        end
        check_eq("latency", 64'(cyc), 64'd5);
        expv = exp_hilo;
        if (sb_q.size() > 0) expv = sb_q.pop_front();
        if (done) begin
            check_eq("result", {hi, lo}, expv);
            check_eq("busy_at_done", 64'(busy), 64'd0);
        end
        exp_hilo = expv;
        if (mode == 1) begin
            @(posedge clk);
            #1;
            check_eq("single_done", 64'(done), 64'd0);
            check_eq("result_kept", {hi, lo}, exp_hilo);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = 32'd0;
        exp_hilo  = 64'd0;
        #12;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check_eq("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        mul_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
        check_eq("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        check_eq("mult_m1xm1", {hi, lo}, 64'h0000_0000_0000_0001);
        mul_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        check_eq("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        mul_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        check_eq("multu_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        mul_op(32'h1234_5678, 32'd0, 1'b1, 0);
        mul_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

        // start while busy is ignored
        mul_op(32'h0001_0003, 32'hFFFE_0007, 1'b1, 1);

        // Reset during P2 aborts the multiply
        @(negedge clk);
        start     = 1'b1;
        a         = 32'hDEAD_BEEF;
        b         = 32'h1357_9BDF;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_hilo = 64'd0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", 64'(done), 64'd0);
        end

        // MTHI/MTLO while idle
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        exp_hilo[63:32] = 32'h1234_5678;
        check_eq("mthi_idle", {hi, lo}, exp_hilo);
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        exp_hilo[31:0] = 32'h0BAD_F00D;
        check_eq("mtlo_idle", {hi, lo}, exp_hilo);

        // Write with accepted start lands, then is overwritten; writes while busy drop
        mul_op(32'h0000_1000, 32'h0000_0010, 1'b0, 2);
        mul_op(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 3);

        // Random sweep; successive ops issue start in the done cycle (back-to-back)
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            rb = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            mul_op(ra, rb, 1'($urandom), 0);
        end

        check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
